fpu_seq_ctrl: RTL

FPU_SEQ_CTRL -- requirements
Module: fpu_seq_ctrl

---
 rtl/fp_ctrl_pkg.sv | 18 +
 rtl/fpu_lat_cnt.sv | 24 ++
 rtl/fpu_seq_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP sequencing control: state encoding, fp_op codes
// and the RV32F arithmetic major opcode.
package fp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } fpState_e;

  localparam logic [1:0] FP_ADD = 2'b00;
  localparam logic [1:0] FP_MUL = 2'b01;
  localparam logic [1:0] FP_DIV = 2'b10;
  localparam logic [1:0] FP_RSV = 2'b11;

  localparam logic [6:0] OPCODE_FP = 7'b1010011;

endpackage

// File: rtl/fpu_lat_cnt.sv
// 4-bit down-counter holding the remaining execute cycles of the in-flight FP op.
module fpu_lat_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] loadVal,
  input  logic       dec,
  output logic [3:0] value,
  output logic       zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= 4'd0;
    end else if (load) begin
      value <= loadVal;
    end else if (dec && (value != 4'd0)) begin
      value <= value - 4'd1;
    end
  end

  assign zero = (value == 4'd0);

endmodule

// File: rtl/fpu_seq_ctrl.sv
// Multi-cycle FP op sequencer: stalls the integer pipe while the FPU executes.
// Optional divide support is enabled with the FPU_DIV_EN macro.
module fpu_seq_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] fp_op,
  input  logic [4:0] rd_in,
  input  logic       flush,
  output logic       stall,
  output logic       fpu_en,
  output logic [1:0] fpu_sel,
  output logic       fp_wb,
  output logic [4:0] wb_rd,
  output logic       illegal
);

  if (LAT_ADD < 1 || LAT_ADD > 15) begin : gBadLatAdd
    $error("LAT_ADD must be within 1..15");
  end
  if (LAT_MUL < 1 || LAT_MUL > 15) begin : gBadLatMul
    $error("LAT_MUL must be within 1..15");
  end
  if (LAT_DIV < 1 || LAT_DIV > 15) begin : gBadLatDiv
    $error("LAT_DIV must be within 1..15");
  end

  fpState_e   state, nextState;
  logic       opLegal;
  logic       accept;
  logic       cntDec;
  logic       cntZero;
  logic [3:0] cntVal;
  logic [3:0] latLoad;

  always_comb begin
    opLegal = (fp_op == FP_ADD) || (fp_op == FP_MUL);
    latLoad = 4'(LAT_ADD - 1);
    if (fp_op == FP_MUL) latLoad = 4'(LAT_MUL - 1);
`ifdef FPU_DIV_EN
    if (fp_op == FP_DIV) begin
      opLegal = 1'b1;
      latLoad = 4'(LAT_DIV - 1);
    end
`endif
  end

  assign accept = (state == IDLE) && start && !flush && opLegal;

  fpu_lat_cnt uLatCnt (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .loadVal (latLoad),
    .dec     (cntDec),
    .value   (cntVal),
    .zero    (cntZero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      fpu_sel <= 2'b00;
      wb_rd   <= 5'd0;
    end else begin
      state <= nextState;
      if (accept) begin
        fpu_sel <= fp_op;
        wb_rd   <= rd_in;
      end
    end
  end

  // Flush in EXEC drops stall in the same cycle so the redirect is not frozen.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    fpu_en    = 1'b0;
    fp_wb     = 1'b0;
    illegal   = 1'b0;
    cntDec    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (opLegal) begin
            stall     = 1'b1;
            nextState = EXEC;
          end else begin
            illegal = 1'b1;
          end
        end
      end
      EXEC: begin
        fpu_en = 1'b1;
        if (flush) begin
          nextState = IDLE;
        end else begin
          stall  = 1'b1;
          cntDec = 1'b1;
          if (cntZero) nextState = WB;
        end
      end
      WB: begin
        fp_wb     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule
